serial_word_receiver: RTL and testbench

- Receive-side counterpart to the universal shift register's serial shift-out path.
- Deserializes a framed, bit-strobed serial stream into WIDTH-bit parallel words. Frame format: start bit, data bits, optional even-parity bit, stop bit.
- Presents each received word on a valid/ready output handshake, with per-word error flags and a sticky overrun flag.
- Sits between a serial link or shift-register chain and a parallel consumer.

---
 rtl/serial_word_receiver.sv | 125 ++++++++++++
 tb/tb_serial_word_receiver.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// Serial word receiver: deserializes start/data/[parity]/stop frames that
// arrive one bit per bit_en strobe, and presents each word on a valid/ready
// handshake with per-word error flags and a sticky overrun flag.
module serial_word_receiver #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             sin,
  input  logic             bit_en,
  input  logic             ready,
  output logic [WIDTH-1:0] O,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             pbit, pbit_n;
  logic [WIDTH-1:0] o_n;
  logic             valid_n, perr_n, ferr_n, ovr_n;
  logic             perr_calc;

  // Even parity over data plus parity bit must be 0; disabled parity never flags.
  assign perr_calc = PARITY_EN ? (^sreg ^ pbit) : 1'b0;
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state, shift path and output-word handshake; everything holds without bit_en.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    pbit_n  = pbit;
    o_n     = O;
    valid_n = valid;
    perr_n  = parity_err;
    ferr_n  = frame_err;
    ovr_n   = overrun;

    // Consumption; a load in the same cycle below overrides valid_n again.
    if (valid && ready) valid_n = 1'b0;

    if (bit_en) begin
      unique case (state)
        IDLE: begin
          if (!sin) begin
            state_n = DATA;
            cnt_n   = '0;
          end
        end
        DATA: begin
          if (MSB_FIRST) sreg_n = {sreg[WIDTH-2:0], sin};
          else           sreg_n = {sin, sreg[WIDTH-1:1]};
          cnt_n = cnt + 1'b1;
          if (cnt == LAST) begin
            cnt_n   = '0;
            state_n = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          pbit_n  = sin;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (!valid || ready) begin
            o_n     = sreg;
            valid_n = 1'b1;
            perr_n  = perr_calc;
            ferr_n  = ~sin;
          end else begin
            ovr_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt        <= '0;
      sreg       <= '0;
      pbit       <= 1'b0;
      O          <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      sreg       <= sreg_n;
      pbit       <= pbit_n;
      O          <= o_n;
      valid      <= valid_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      overrun    <= ovr_n;
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed testbench for serial_word_receiver (WIDTH=4, LSB first, even parity).
module tb_serial_word_receiver;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       sin = 1'b1;
  logic       bit_en = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] O;
  logic       valid, parity_err, frame_err, overrun, busy;

  int asserts = 0;
  int fails = 0;

  serial_word_receiver #(.WIDTH(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut (
    .clk(clk), .clear(clear), .sin(sin), .bit_en(bit_en), .ready(ready),
    .O(O), .valid(valid), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // One strobed bit on the next cycle; gap idle cycles follow.
  task automatic send_bit(input logic b, input logic rdy, input int unsigned gap);
    @(negedge clk);
    sin = b; bit_en = 1'b1; ready = rdy;
    @(negedge clk);
    bit_en = 1'b0; ready = 1'b0; sin = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Start, 4 data bits LSB first, parity bit, stop bit (ready applied on stop strobe).
  task automatic send_frame(input logic [3:0] d, input logic p, input logic stp, input logic rdy);
    send_bit(1'b0, 1'b0, 3);
    for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0, 3);
    send_bit(p, 1'b0, 3);
    send_bit(stp, rdy, 3);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (3) @(negedge clk);
    asserts++; if (O !== 4'b0000) begin fails++; $display("FAIL reset_O got %b exp 0000", O); end
    asserts++; if ({valid, parity_err, frame_err, overrun, busy} !== 5'b0) begin fails++; $display("FAIL reset_flags got %b exp 00000", {valid, parity_err, frame_err, overrun, busy}); end
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean();
    send_bit(1'b0, 1'b0, 3);
    asserts++; if (busy !== 1'b1) begin fails++; $display("FAIL clean_busy_start got %b exp 1", busy); end
    send_bit(1'b1, 1'b0, 3); send_bit(1'b0, 1'b0, 3); send_bit(1'b0, 1'b0, 3); send_bit(1'b1, 1'b0, 3);
    send_bit(1'b0, 1'b0, 3);
    asserts++; if (valid !== 1'b0) begin fails++; $display("FAIL clean_valid_pre got %b exp 0", valid); end
    send_bit(1'b1, 1'b0, 0);
    asserts++; if (valid !== 1'b1) begin fails++; $display("FAIL clean_latency_valid got %b exp 1", valid); end
    asserts++; if (O !== 4'b1001) begin fails++; $display("FAIL clean_O got %b exp 1001", O); end
    asserts++; if ({parity_err, frame_err, busy} !== 3'b000) begin fails++; $display("FAIL clean_flags got %b exp 000", {parity_err, frame_err, busy}); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    asserts++; if (valid !== 1'b0) begin fails++; $display("FAIL clean_consume_valid got %b exp 0", valid); end
    asserts++; if (O !== 4'b1001) begin fails++; $display("FAIL clean_consume_O got %b exp 1001", O); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_parity_err();
    send_frame(4'b0111, 1'b0, 1'b1, 1'b0);
    asserts++; if (O !== 4'b0111) begin fails++; $display("FAIL perr_O got %b exp 0111", O); end
    asserts++; if ({valid, parity_err, frame_err} !== 3'b110) begin fails++; $display("FAIL perr_flags got %b exp 110", {valid, parity_err, frame_err}); end
    ready = 1'b1; @(negedge clk); ready = 1'b0;
  endtask

  task automatic test_frame_err();
    send_frame(4'b1010, 1'b0, 1'b0, 1'b0);
    asserts++; if (O !== 4'b1010) begin fails++; $display("FAIL ferr_O got %b exp 1010", O); end
    asserts++; if ({valid, parity_err, frame_err, busy} !== 4'b1010) begin fails++; $display("FAIL ferr_flags got %b exp 1010", {valid, parity_err, frame_err, busy}); end
    ready = 1'b1; @(negedge clk); ready = 1'b0;
  endtask

  task automatic test_overrun();
    do_clear();
    send_frame(4'b1001, 1'b0, 1'b1, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b0, 1'b0);
    asserts++; if (O !== 4'b1001) begin fails++; $display("FAIL ovr_O got %b exp 1001", O); end
    asserts++; if ({valid, parity_err, frame_err, overrun} !== 4'b1001) begin fails++; $display("FAIL ovr_flags got %b exp 1001", {valid, parity_err, frame_err, overrun}); end
    // Same-cycle consume and load on the second stop strobe.
    do_clear();
    send_frame(4'b1001, 1'b0, 1'b1, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b1, 1'b1);
    asserts++; if (O !== 4'b0110) begin fails++; $display("FAIL simul_O got %b exp 0110", O); end
    asserts++; if ({valid, overrun} !== 2'b10) begin fails++; $display("FAIL simul_flags got %b exp 10", {valid, overrun}); end
  endtask

  task automatic test_reset_midframe();
    // Leave a previous stale word in place, then reset partway into a new frame.
    send_bit(1'b0, 1'b0, 3); send_bit(1'b1, 1'b0, 3); send_bit(1'b1, 1'b0, 3);
    @(negedge clk);
    clear = 1'b1;
    #1;
    asserts++; if ({O, valid, parity_err, frame_err, overrun, busy} !== 9'b0) begin fails++; $display("FAIL midreset_outputs got %b exp 0", {O, valid, parity_err, frame_err, overrun, busy}); end
    @(negedge clk);
    clear = 1'b0;
    send_frame(4'b0011, 1'b0, 1'b1, 1'b0);
    asserts++; if (O !== 4'b0011) begin fails++; $display("FAIL midreset_O got %b exp 0011", O); end
    asserts++; if ({valid, parity_err, frame_err, overrun} !== 4'b1000) begin fails++; $display("FAIL midreset_flags got %b exp 1000", {valid, parity_err, frame_err, overrun}); end
    ready = 1'b1; @(negedge clk); ready = 1'b0;
  endtask

  task automatic test_strobe_gating();
    int unsigned errs = 0;
    do_clear();
    for (int i = 0; i < 20; i++) begin
      sin = i[0];
      @(negedge clk);
      asserts++; if ({busy, valid} !== 2'b00) begin fails++; errs++; if (errs < 4) $display("FAIL gate_idle cycle %0d got %b exp 00", i, {busy, valid}); end
    end
    // Gaps inside a frame must not shift data in.
    send_bit(1'b0, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      sin = i[0];
      @(negedge clk);
    end
    asserts++; if (busy !== 1'b1) begin fails++; $display("FAIL gate_hold_busy got %b exp 1", busy); end
    send_bit(1'b0, 1'b0, 3); send_bit(1'b1, 1'b0, 3); send_bit(1'b0, 1'b0, 3); send_bit(1'b1, 1'b0, 3);
    send_bit(1'b0, 1'b0, 3); send_bit(1'b1, 1'b0, 3);
    asserts++; if ({O, valid, parity_err, frame_err} !== 7'b1010100) begin fails++; $display("FAIL gate_word got %b exp 1010100", {O, valid, parity_err, frame_err}); end
    ready = 1'b1; @(negedge clk); ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_clear();
    // ready high while empty must be ignored.
    ready = 1'b1; @(negedge clk); ready = 1'b0;
    send_frame(4'b0111, 1'b0, 1'b1, 1'b0);
    asserts++; if ({O, parity_err} !== 5'b01111) begin fails++; $display("FAIL b2b_first got %b exp 01111", {O, parity_err}); end
    send_frame(4'b1011, 1'b1, 1'b1, 1'b1);
    asserts++; if ({O, valid, parity_err, frame_err, overrun} !== 8'b10111000) begin fails++; $display("FAIL b2b_second got %b exp 10111000", {O, valid, parity_err, frame_err, overrun}); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_strobe_gating();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
